// File: rtl/bram_scan_driver.sv
// Initiator for one simple-dual-port block RAM: streams its contents out
// (dump mode) or writes a seeded pattern and reads it back (test mode).
module bram_scan_driver #(
  parameter int WID_MEM   = 1,
  parameter int DEPTH_MEM = 128,
  parameter int ADDR_W    = 7
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               mode,
  input  logic [WID_MEM-1:0] seed,
  output logic [ADDR_W-1:0]  mem_raddr,
  input  logic [WID_MEM-1:0] mem_dout,
  output logic [ADDR_W-1:0]  mem_waddr,
  output logic [WID_MEM-1:0] mem_din,
  output logic               mem_we,
  output logic               dump_valid,
  input  logic               dump_ready,
  output logic [ADDR_W-1:0]  dump_addr,
  output logic [WID_MEM-1:0] dump_data,
  output logic               busy,
  output logic               done,
  output logic [15:0]        err_count,
  output logic [ADDR_W-1:0]  first_err_addr
);

  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] DUMP_RD  = 3'd1;
  localparam logic [2:0] DUMP_OUT = 3'd2;
  localparam logic [2:0] WRITE    = 3'd3;
  localparam logic [2:0] VERIFY   = 3'd4;
  localparam logic [2:0] DONE     = 3'd5;

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH_MEM - 1);

  logic [2:0]         state;
  logic [ADDR_W-1:0]  cnt;
  logic [ADDR_W-1:0]  raddr_q;
  logic               dump_valid_q;
  logic [ADDR_W-1:0]  dump_addr_q;
  logic [WID_MEM-1:0] dump_hold;
  logic               out_first;
  logic [WID_MEM-1:0] seed_q;
  logic               rd_done;
  logic               pend_valid;
  logic [WID_MEM-1:0] pend_exp;
  logic [ADDR_W-1:0]  pend_addr;
  logic [15:0]        err_q;
  logic [ADDR_W-1:0]  first_q;
  logic [WID_MEM-1:0] cnt_w;
  logic [WID_MEM-1:0] exp_now;

  // Counter bits folded into the pattern: truncated or zero-extended to the word.
  generate
    if (WID_MEM <= ADDR_W) begin : g_trunc
      assign cnt_w = cnt[WID_MEM-1:0];
    end else begin : g_ext
      assign cnt_w = {{(WID_MEM-ADDR_W){1'b0}}, cnt};
    end
  endgenerate

  assign exp_now = seed_q ^ cnt_w;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      cnt          <= '0;
      raddr_q      <= '0;
      dump_valid_q <= 1'b0;
      dump_addr_q  <= '0;
      dump_hold    <= '0;
      out_first    <= 1'b0;
      seed_q       <= '0;
      rd_done      <= 1'b0;
      pend_valid   <= 1'b0;
      pend_exp     <= '0;
      pend_addr    <= '0;
      err_q        <= '0;
      first_q      <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state      <= mode ? WRITE : DUMP_RD;
            cnt        <= '0;
            err_q      <= '0;
            first_q    <= '0;
            seed_q     <= seed;
            rd_done    <= 1'b0;
            pend_valid <= 1'b0;
            if (!mode) raddr_q <= '0;
          end
        end
        DUMP_RD: begin
          state        <= DUMP_OUT;
          dump_valid_q <= 1'b1;
          dump_addr_q  <= cnt;
          out_first    <= 1'b1;
        end
        DUMP_OUT: begin
          // The first beat cycle passes mem_dout straight through; the held copy covers stalls.
          out_first <= 1'b0;
          if (out_first) dump_hold <= mem_dout;
          if (dump_ready) begin
            dump_valid_q <= 1'b0;
            if (cnt == LAST) begin
              state <= DONE;
            end else begin
              cnt     <= cnt + ADDR_W'(1);
              raddr_q <= cnt + ADDR_W'(1);
              state   <= DUMP_RD;
            end
          end
        end
        WRITE: begin
          if (cnt == LAST) begin
            cnt        <= '0;
            raddr_q    <= '0;
            rd_done    <= 1'b0;
            pend_valid <= 1'b0;
            state      <= VERIFY;
          end else begin
            cnt <= cnt + ADDR_W'(1);
          end
        end
        VERIFY: begin
          // Read issued this cycle is compared next cycle against the delayed expectation.
          pend_valid <= !rd_done;
          pend_exp   <= exp_now;
          pend_addr  <= cnt;
          if (!rd_done) begin
            if (cnt == LAST) begin
              rd_done <= 1'b1;
            end else begin
              cnt     <= cnt + ADDR_W'(1);
              raddr_q <= cnt + ADDR_W'(1);
            end
          end else begin
            state <= DONE;
          end
          if (pend_valid && (mem_dout != pend_exp)) begin
            if (err_q != 16'hFFFF) err_q <= err_q + 16'd1;
            if (err_q == 16'd0) first_q <= pend_addr;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Write strobe decodes straight from state so an async reset kills it at once.
  assign mem_we         = (state == WRITE);
  assign mem_waddr      = cnt;
  assign mem_din        = exp_now;
  assign mem_raddr      = raddr_q;
  assign dump_valid     = dump_valid_q;
  assign dump_addr      = dump_addr_q;
  assign dump_data      = out_first ? mem_dout : dump_hold;
  assign busy           = (state != IDLE) && (state != DONE);
  assign done           = (state == DONE);
  assign err_count      = err_q;
  assign first_err_addr = first_q;

endmodule

// File: tb/tb_bram_scan_driver.sv
// Directed bench for bram_scan_driver with a behavioural registered-output BRAM.
module tb_bram_scan_driver;

  logic       clk;
  logic       reset;
  logic       start;
  logic       mode;
  logic [0:0] seed;
  logic [6:0] mem_raddr;
  logic [0:0] mem_dout;
  logic [6:0] mem_waddr;
  logic [0:0] mem_din;
  logic       mem_we;
  logic       dump_valid;
  logic       dump_ready;
  logic [6:0] dump_addr;
  logic [0:0] dump_data;
  logic       busy;
  logic       done;
  logic [15:0] err_count;
  logic [6:0] first_err_addr;

  logic       mem [128];
  logic       dout_q;
  logic [6:0] dout_addr;
  logic       load_img;
  logic       inject;
  logic       tb_seed;

  int checks;
  int errors;
  int we_total;
  int din_bad;
  int wa_bad;
  logic       prev_we;
  logic [6:0] prev_wa;

  bram_scan_driver #(.WID_MEM(1), .DEPTH_MEM(128), .ADDR_W(7)) dut (
    .clk(clk), .reset(reset), .start(start), .mode(mode), .seed(seed),
    .mem_raddr(mem_raddr), .mem_dout(mem_dout), .mem_waddr(mem_waddr),
    .mem_din(mem_din), .mem_we(mem_we), .dump_valid(dump_valid),
    .dump_ready(dump_ready), .dump_addr(dump_addr), .dump_data(dump_data),
    .busy(busy), .done(done), .err_count(err_count),
    .first_err_addr(first_err_addr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model: registered read port, optional bit flip at addresses 5 and 9.
  always @(posedge clk) begin
    if (load_img) begin
      for (int i = 0; i < 128; i++) mem[i] <= 1'(i & 1);
    end else if (mem_we) begin
      mem[mem_waddr] <= mem_din[0];
    end
    dout_q    <= mem[mem_raddr];
    dout_addr <= mem_raddr;
  end

  assign mem_dout = dout_q ^ (inject && (dout_addr == 7'd5 || dout_addr == 7'd9));

  // Write-port monitor: pattern and address sequencing for every write cycle.
  always @(negedge clk) begin
    if (mem_we) begin
      we_total++;
      if (mem_din[0] !== (tb_seed ^ mem_waddr[0])) din_bad++;
      if (mem_waddr !== (prev_we ? 7'(prev_wa + 7'd1) : 7'd0)) wa_bad++;
    end
    prev_we = mem_we;
    prev_wa = mem_waddr;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic apply_start(input logic m, input logic s);
    @(negedge clk);
    #1;
    start   = 1'b1;
    mode    = m;
    seed    = s;
    tb_seed = s;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int n0, output int n);
    n = n0;
    do begin
      @(negedge clk);
      n++;
    end while (!done && n < 600);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_output({tag, "_ctrl"}, {mem_raddr, mem_waddr, mem_din, mem_we, dump_valid,
                                  dump_addr, dump_data, busy, done}, 32'd0);
    check_output({tag, "_err"}, {16'd0, err_count}, 32'd0);
    check_output({tag, "_first"}, {25'd0, first_err_addr}, 32'd0);
  endtask

  int n;
  int bad;
  int beats;
  int next_addr;
  int stall_bad;
  int order_bad;
  int we0;
  logic prev_stall;
  logic [6:0] p_addr;
  logic p_data;
  logic r;

  initial begin
    checks = 0; errors = 0; we_total = 0; din_bad = 0; wa_bad = 0;
    prev_we = 1'b0; prev_wa = '0;
    reset = 1'b0; start = 1'b0; mode = 1'b0; seed = '0; tb_seed = 1'b0;
    dump_ready = 1'b1; load_img = 1'b0; inject = 1'b0;

    #12;
    check_reset_outputs("reset");
    @(negedge clk); #1 reset = 1'b1; load_img = 1'b1;
    @(negedge clk); #1 load_img = 1'b0;

    // Dump of the init image with ready held high: one beat every two cycles.
    apply_start(1'b0, 1'b0);
    @(negedge clk);
    check_output("dump_c1_valid", {31'd0, dump_valid}, 32'd0);
    check_output("dump_c1_busy", {31'd0, busy}, 32'd1);
    bad = 0; beats = 0;
    for (int k = 0; k < 128; k++) begin
      @(negedge clk);
      if (dump_valid === 1'b1) beats++;
      if (dump_valid !== 1'b1 || dump_addr !== 7'(k) || dump_data[0] !== k[0]) bad++;
      @(negedge clk);
      if (k < 127 && dump_valid !== 1'b0) bad++;
    end
    check_output("dump_beats", beats, 128);
    check_output("dump_seq_bad", bad, 0);
    check_output("dump_done", {31'd0, done}, 32'd1);
    check_output("dump_busy", {31'd0, busy}, 32'd0);

    // Dump with random back-pressure.
    apply_start(1'b0, 1'b0);
    next_addr = 0; stall_bad = 0; order_bad = 0; prev_stall = 1'b0; n = 0;
    p_addr = '0; p_data = 1'b0;
    while (!done && n < 3000) begin
      @(negedge clk);
      n++;
      if (prev_stall && (dump_valid !== 1'b1 || dump_addr !== p_addr || dump_data[0] !== p_data))
        stall_bad++;
      r = 1'($urandom_range(0, 1));
      #1 dump_ready = r;
      if (dump_valid && r) begin
        if (dump_addr !== next_addr[6:0] || dump_data[0] !== next_addr[0]) order_bad++;
        next_addr++;
      end
      prev_stall = dump_valid && !r;
      p_addr = dump_addr;
      p_data = dump_data[0];
    end
    #1 dump_ready = 1'b1;
    check_output("rdump_beats", next_addr, 128);
    check_output("rdump_stall_bad", stall_bad, 0);
    check_output("rdump_order_bad", order_bad, 0);

    // Test mode, seed 1, clean memory.
    we0 = we_total;
    apply_start(1'b1, 1'b1);
    @(negedge clk);
    check_output("wr_c1", {29'd0, mem_we, mem_din, mem_waddr[0]}, {29'd0, 3'b110});
    @(negedge clk);
    check_output("wr_c2", {24'd0, mem_we, mem_din, mem_waddr}, {24'd0, 2'b10, 7'd1});
    wait_done(2, n);
    check_output("t1_len", n, 258);
    check_output("t1_err", {16'd0, err_count}, 32'd0);
    check_output("t1_first", {25'd0, first_err_addr}, 32'd0);
    check_output("t1_we_cycles", we_total - we0, 128);
    check_output("t1_din_bad", din_bad, 0);
    check_output("t1_wa_bad", wa_bad, 0);

    // Injected read faults at addresses 5 and 9.
    inject = 1'b1;
    apply_start(1'b1, 1'b0);
    wait_done(0, n);
    inject = 1'b0;
    check_output("t2_len", n, 258);
    check_output("t2_err", {16'd0, err_count}, 32'd2);
    check_output("t2_first", {25'd0, first_err_addr}, 32'd5);

    // Reset mid-WRITE at address 40.
    apply_start(1'b1, 1'b1);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(mem_we && mem_waddr == 7'd40) && n < 200);
    check_output("abort_reach40", n, 41);
    #1 reset = 1'b0;
    #1;
    check_reset_outputs("abort");
    we0 = we_total;
    repeat (3) @(negedge clk);
    #1 reset = 1'b1;
    repeat (3) @(negedge clk);
    check_output("abort_no_we", we_total - we0, 0);
    check_output("abort_mem39", {31'd0, mem[39]}, 32'd0);
    check_output("abort_mem40", {31'd0, mem[40]}, 32'd0);
    we0 = we_total;
    apply_start(1'b1, 1'b1);
    wait_done(0, n);
    check_output("t3_len", n, 258);
    check_output("t3_err", {16'd0, err_count}, 32'd0);
    check_output("t3_we_cycles", we_total - we0, 128);

    // Start pulsed during VERIFY must be ignored.
    inject = 1'b1;
    apply_start(1'b1, 1'b1);
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (n == 200) begin
        #1 start = 1'b1; mode = 1'b0;
      end else if (n == 201) begin
        check_output("ign_busy", {31'd0, busy}, 32'd1);
        check_output("ign_err_kept", {16'd0, err_count}, 32'd2);
        #1 start = 1'b0;
      end
    end while (!done && n < 600);
    inject = 1'b0;
    check_output("t4_len", n, 258);
    check_output("t4_err", {16'd0, err_count}, 32'd2);
    check_output("t4_first", {25'd0, first_err_addr}, 32'd5);
    check_output("final_din_bad", din_bad, 0);
    check_output("final_wa_bad", wa_bad, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/bram_scan_driver.md
Name: bram_scan_driver

Overview:
- Controller that drives the write and read ports of one simple-dual-port block-RAM instance: the initiator end of the memory's raddr/waddr/din/dout interface.
- Two operations per start command:
  - Dump mode: streams the memory's current contents (for example the `$readmemh`-loaded init image) out over a valid/ready port, address 0 first, for comparison against the patched bitstream.
  - Test mode: writes a seeded pattern to every word, reads it back and compares.
- Sits beside the memory under test in bitstream-patch test designs.

Parameters:
- WID_MEM, 1, data width of the memory word.
- DEPTH_MEM, 128, number of words. Must be a power of two, at least 2.
- ADDR_W, 7, address width. Must equal log2(DEPTH_MEM).

Ports:
- clk  input  1  clock; all logic is rising-edge.
- reset  input  1  asynchronous active-low reset.
- start  input  1  one-cycle request. Ignored unless the state is IDLE or DONE.
- mode  input  1  sampled with start: 0 = dump, 1 = write/verify.
- seed  input  WID_MEM  pattern seed, sampled with start.
- mem_raddr  output  ADDR_W  memory read address.
- mem_dout  input  WID_MEM  memory read data. It is registered in the memory: the value for the raddr presented in cycle N appears in cycle N+1.
- mem_waddr  output  ADDR_W  memory write address.
- mem_din  output  WID_MEM  memory write data.
- mem_we  output  1  write enable. The memory write is gated by this signal.
- dump_valid  output  1  dump beat valid.
- dump_ready  input  1  dump consumer ready.
- dump_addr  output  ADDR_W  address of the current dump beat.
- dump_data  output  WID_MEM  data of the current dump beat.
- busy  output  1  high in any state other than IDLE and DONE.
- done  output  1  high in DONE; stays high until the next accepted start or reset.
- err_count  output  16  verify mismatch count; saturates at 0xFFFF.
- first_err_addr  output  ADDR_W  address of the first mismatch. Holds 0 if there was none.

Behaviour:
- Reset (async assert, sync release): state IDLE. Every output is 0, including mem_we, dump_valid, done, err_count and first_err_addr.
- A reset arriving mid-operation aborts immediately:
  - mem_we drops in the same instant, so no further writes occur.
  - Partially written memory contents are left as they are.
- States: IDLE, DUMP_RD, DUMP_OUT, WRITE, VERIFY, DONE.
- Accepted start: clears done, err_count and first_err_addr, and sets the address counter to 0. It then moves to DUMP_RD (mode 0) or WRITE (mode 1).
- DUMP_RD: drives mem_raddr = counter for one cycle, then goes to DUMP_OUT.
- DUMP_OUT:
  - Registers mem_dout into dump_data and the counter into dump_addr, with dump_valid = 1.
  - dump_data and dump_addr stay stable while dump_valid && !dump_ready.
  - On handshake, the counter increments and the state returns to DUMP_RD. After the last address, the state goes to DONE instead.
  - Throughput: one beat per 2 cycles when dump_ready is held high.
  - No beat is lost or duplicated under any dump_ready pattern.
- WRITE:
  - One word per cycle with mem_we = 1, mem_waddr = counter, and mem_din = seed XOR counter[WID_MEM-1:0]. The counter bits are zero-extended when WID_MEM > ADDR_W.
  - After address DEPTH_MEM-1, the counter resets to 0 and the state goes to VERIFY.
- VERIFY:
  - Pipelined: a read is issued every cycle, and the compare happens one cycle later against the expected value delayed by one cycle.
  - On a mismatch, err_count increments (saturating). If this is the first mismatch, first_err_addr captures the address.
  - Enters DONE one cycle after the last read, once its compare has completed.
- mem_we is 0 in every state except WRITE. mem_raddr holds its last value when unused.
- Address wrap: the counter never exceeds DEPTH_MEM-1. Reaching the terminal count is the exit condition for each phase.
- A start that arrives while busy has no effect.

Test Plan:
- Dump, init image = address[0] pattern, DEPTH 128, dump_ready=1 → 128 beats with dump_addr 0..127 and dump_data 0,1,0,1…; first dump_valid in cycle 2 after start; done on the cycle after beat 127; busy=0.
- Dump with dump_ready toggling at random → identical beat sequence, no repeats or gaps; dump_data stable while stalled.
- Test mode, seed=1, clean memory → mem_din sequence 1,0,1,0…; exactly 128 mem_we cycles; err_count=0 and first_err_addr=0 at done.
- Test mode with the bench forcing mem_dout inverted at addresses 5 and 9 → err_count=2, first_err_addr=5.
- Reset pulled low during WRITE at address 40 → all outputs 0 asynchronously, no mem_we afterwards; a following start runs to completion normally.
- start pulsed during VERIFY → ignored: err_count is not cleared and the run length is unchanged.
